button_pulse_conditioner: RTL and testbench
===========================================

BUTTON_PULSE_CONDITIONER -- requirements
Module: button_pulse_conditioner

Interface
- REQ-001: Parameter SYNC_STAGES, 2, synchroniser depth per button; legal range 2..4.
- REQ-002: Parameter DEBOUNCE_CYCLES, 1000000, cycles an input must stay at a new level before it is accepted (10 ms at 100 MHz); legal range 2..2^24-1.
- REQ-003: clk  input  1  single system clock; all logic on rising edge.
- REQ-004: reset  input  1  asynchronous, active-low reset; asserted when 0.
- REQ-005: higher_raw  input  1  raw higher pushbutton, asynchronous to clk, bouncy.
- REQ-006: lower_raw  input  1  raw lower pushbutton, asynchronous to clk, bouncy.
- REQ-007: confirm_raw  input  1  raw confirm pushbutton, asynchronous to clk, bouncy.
- REQ-008: higher_btn  output  1  one-cycle pulse per accepted higher press; feeds game FSM higher input.
- REQ-009: lower_btn  output  1  one-cycle pulse per accepted lower press.
- REQ-010: confirm_btn  output  1  one-cycle pulse per accepted confirm press.
- REQ-011: btn_level  output  3  debounced levels {confirm, higher, lower}, bit 2 = confirm.

Function
- REQ-012: Each raw input SHALL pass through a SYNC_STAGES-flop synchroniser before any other use.
- REQ-013: Per button, while synced level differs from debounced level, a counter SHALL increment each cycle; a return to equality SHALL clear it to 0 the same cycle.
- REQ-014: When the counter reaches DEBOUNCE_CYCLES-1 with the level still differing, the debounced level SHALL take the synced value next cycle and the counter SHALL clear.
- REQ-015: A 0->1 transition of a debounced level SHALL be a press event; 1->0 transitions SHALL produce no pulse.
- REQ-016: Pulse outputs SHALL be registered, high exactly one cycle, asserted the cycle after the debounced level rises; total latency from a clean raw edge = SYNC_STAGES + DEBOUNCE_CYCLES + 1 cycles.
- REQ-017: Pulse outputs SHALL be mutually exclusive; on simultaneous press events priority is confirm > higher > lower, and losing events SHALL be discarded, not queued.
- REQ-018: Arbiter FSM states: ARMED (pulses allowed), LOCKED (pulses suppressed).
- REQ-019: ARMED -> LOCKED in the cycle a pulse is issued; LOCKED -> ARMED when all three debounced levels are 0; suppressed presses in LOCKED SHALL be discarded.
- REQ-020: Any input pulse shorter than DEBOUNCE_CYCLES synced cycles SHALL produce no pulse and no btn_level change.
- REQ-021: Counters SHALL saturate, never wrap, and be sized ceil(log2(DEBOUNCE_CYCLES)) bits.

Reset
- REQ-022: Asserting reset SHALL immediately clear synchronisers, counters, btn_level and all pulse outputs to 0, and set FSM to ARMED.
- REQ-023: Reset mid-debounce SHALL discard the count; a button held through reset release SHALL yield exactly one pulse after a full re-debounce.

Configuration
- REQ-024: Macro BTN_LOCKOUT_EN defined: FSM of REQ-018/019 present.
- REQ-025: BTN_LOCKOUT_EN undefined: no FSM; every press event pulses subject only to REQ-017 priority.

Structure
- REQ-026: Shared package higher_or_lower_pkg SHALL hold button index constants (BTN_LOWER=0, BTN_HIGHER=1, BTN_CONFIRM=2), default DEBOUNCE_CYCLES and the ARMED/LOCKED encodings.
- REQ-027: Sub-module btn_debounce (synchroniser, counter, debounced level, rise flag) SHALL be instantiated three times; arbitration and FSM stay in the top.

Verification (SYNC_STAGES=2, DEBOUNCE_CYCLES=4)
- REQ-028: higher_raw 0->1 held 20 cycles -> higher_btn high exactly one cycle, 7 cycles after edge; btn_level=3'b010 thereafter.
- REQ-029: lower_raw toggles every 2 cycles for 10 cycles then stays 1 -> exactly one lower_btn pulse, 7 cycles after last edge.
- REQ-030: lower_raw high 3 cycles then low -> no pulse, btn_level stays 0.
- REQ-031: confirm_raw and higher_raw rise same cycle -> only confirm_btn pulses; higher_btn never pulses.
- REQ-032: BTN_LOCKOUT_EN: hold higher, press lower while held -> no lower_btn; release both, press lower -> one pulse; macro undefined -> lower_btn pulses while higher held.
- REQ-033: reset=0 two cycles into higher debounce, released with higher held -> outputs 0 during reset, one higher_btn pulse 7 cycles after release.

Source files
------------

// File: rtl/higher_or_lower_pkg.sv
// Shared constants for the higher-or-lower game front end: button indices,
// default debounce length and the press-arbiter state encodings.
package higher_or_lower_pkg;

  localparam int BTN_LOWER   = 0;
  localparam int BTN_HIGHER  = 1;
  localparam int BTN_CONFIRM = 2;
  localparam int NUM_BTN     = 3;

  // 10 ms at 100 MHz
  localparam int DEBOUNCE_CYCLES_DEFAULT = 1000000;

  // ARMED: pulses may be issued. LOCKED: pulses suppressed until all released.
  typedef enum logic {
    ARMED  = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

endpackage

// File: rtl/btn_debounce.sv
// One pushbutton channel: multi-flop synchroniser, saturating debounce counter,
// debounced level and a one-cycle rise flag raised with the accepted 0->1 change.
module btn_debounce
  import higher_or_lower_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CNT_W-1:0]       cnt_q;

  // Shift the raw button through the synchroniser chain; nothing else sees raw.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
    end
  end

  assign synced = sync_q[SYNC_STAGES-1];

  // Count while the synced level disagrees; accept it once it has disagreed for
  // DEBOUNCE_CYCLES cycles. Any return to agreement restarts the count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (synced == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level <= synced;
        cnt_q <= '0;
        rise  <= synced;
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_ONE;
      end
    end
  end

endmodule

// File: rtl/button_pulse_conditioner.sv
// Conditions the three raw game buttons into debounced levels and mutually
// exclusive one-cycle press pulses (priority confirm > higher > lower).
// Build option BTN_LOCKOUT_EN: when defined, an ARMED/LOCKED arbiter allows one
// pulse and then ignores further presses until every button is released.
module button_pulse_conditioner
  import higher_or_lower_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       higher_raw,
  input  logic       lower_raw,
  input  logic       confirm_raw,
  output logic       higher_btn,
  output logic       lower_btn,
  output logic       confirm_btn,
  output logic [2:0] btn_level
);

  logic [NUM_BTN-1:0] raw_vec;
  logic [NUM_BTN-1:0] rise_vec;
  logic [NUM_BTN-1:0] grant;
  logic [NUM_BTN-1:0] pulse_q;
  logic               issue_en;

  assign raw_vec[BTN_LOWER]   = lower_raw;
  assign raw_vec[BTN_HIGHER]  = higher_raw;
  assign raw_vec[BTN_CONFIRM] = confirm_raw;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .raw   (raw_vec[i]),
      .level (btn_level[i]),
      .rise  (rise_vec[i])
    );
  end

  // Fixed-priority pick among simultaneous press events; losers are dropped.
  always_comb begin
    grant = '0;
    if (rise_vec[BTN_CONFIRM]) begin
      grant[BTN_CONFIRM] = 1'b1;
    end else if (rise_vec[BTN_HIGHER]) begin
      grant[BTN_HIGHER] = 1'b1;
    end else if (rise_vec[BTN_LOWER]) begin
      grant[BTN_LOWER] = 1'b1;
    end
  end

`ifdef BTN_LOCKOUT_EN
  arb_state_t state_q;
  arb_state_t state_d;

  // Arbiter state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ARMED;
    end else begin
      state_q <= state_d;
    end
  end

  // Lock after issuing a pulse; re-arm only once every button is released.
  always_comb begin
    state_d  = state_q;
    issue_en = 1'b0;
    case (state_q)
      ARMED: begin
        issue_en = 1'b1;
        if (|grant) state_d = LOCKED;
      end
      LOCKED: begin
        if (btn_level == 3'b000) state_d = ARMED;
      end
      default: state_d = ARMED;
    endcase
  end
`else
  assign issue_en = 1'b1;
`endif

  // Register the granted press so each output is a clean single-cycle pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pulse_q <= '0;
    end else begin
      pulse_q <= issue_en ? grant : '0;
    end
  end

  assign lower_btn   = pulse_q[BTN_LOWER];
  assign higher_btn  = pulse_q[BTN_HIGHER];
  assign confirm_btn = pulse_q[BTN_CONFIRM];

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Directed bench for button_pulse_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4
// (clean edge to pulse = 7 cycles).
module tb_button_pulse_conditioner;

`ifdef BTN_LOCKOUT_EN
  localparam int LOCKOUT = 1;
`else
  localparam int LOCKOUT = 0;
`endif

  logic       clk;
  logic       reset;
  logic       higher_raw;
  logic       lower_raw;
  logic       confirm_raw;
  logic       higher_btn;
  logic       lower_btn;
  logic       confirm_btn;
  logic [2:0] btn_level;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int mark    = 0;
  int n_hi, n_lo, n_cf, n_ovl;
  int first_hi, first_lo, first_cf;
  int last_edge;
  logic [2:0] lvl_or;

  button_pulse_conditioner #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .higher_raw  (higher_raw),
    .lower_raw   (lower_raw),
    .confirm_raw (confirm_raw),
    .higher_btn  (higher_btn),
    .lower_btn   (lower_btn),
    .confirm_btn (confirm_btn),
    .btn_level   (btn_level)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  // Advance one clock and sample outputs 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (higher_btn) begin n_hi++; if (first_hi < 0) first_hi = cyc; end
    if (lower_btn) begin n_lo++; if (first_lo < 0) first_lo = cyc; end
    if (confirm_btn) begin n_cf++; if (first_cf < 0) first_cf = cyc; end
    if (int'(higher_btn) + int'(lower_btn) + int'(confirm_btn) > 1) n_ovl++;
    lvl_or = lvl_or | btn_level;
  endtask

  task automatic clear_counts();
    n_hi = 0; n_lo = 0; n_cf = 0;
    first_hi = -1; first_lo = -1; first_cf = -1;
    lvl_or = 3'b000;
    mark = cyc;
  endtask

  initial begin
    n_ovl = 0;
    clear_counts();
    reset = 1'b0; higher_raw = 1'b0; lower_raw = 1'b0; confirm_raw = 1'b0;
    repeat (3) step();
    check("rst_level", btn_level, 3'b000);
    check("rst_pulses", {confirm_btn, higher_btn, lower_btn}, 3'b000);
    reset = 1'b1;
    repeat (2) step();

    // single clean higher press
    clear_counts();
    higher_raw = 1'b1;
    repeat (20) step();
    check("t28_hi_count", n_hi, 1);
    check("t28_hi_latency", first_hi - mark, 7);
    check("t28_other_pulses", n_lo + n_cf, 0);
    check("t28_level", btn_level, 3'b010);
    clear_counts();
    higher_raw = 1'b0;
    repeat (10) step();
    check("t28_release_pulses", n_hi + n_lo + n_cf, 0);
    check("t28_release_level", btn_level, 3'b000);

    // bouncy lower press, settles high
    clear_counts();
    last_edge = 0;
    for (int i = 0; i < 5; i++) begin
      lower_raw = (i % 2 == 0);
      if (i == 4) last_edge = cyc;
      else repeat (2) step();
    end
    repeat (12) step();
    check("t29_lo_count", n_lo, 1);
    check("t29_lo_latency", first_lo - last_edge, 7);
    check("t29_level", btn_level, 3'b001);
    lower_raw = 1'b0;
    repeat (10) step();

    // glitch shorter than the debounce window
    clear_counts();
    lower_raw = 1'b1;
    repeat (3) step();
    lower_raw = 1'b0;
    repeat (10) step();
    check("t30_lo_count", n_lo, 0);
    check("t30_level_seen", lvl_or, 3'b000);

    // simultaneous confirm + higher
    clear_counts();
    confirm_raw = 1'b1; higher_raw = 1'b1;
    repeat (20) step();
    check("t31_cf_count", n_cf, 1);
    check("t31_cf_latency", first_cf - mark, 7);
    check("t31_hi_count", n_hi, 0);
    check("t31_level", btn_level, 3'b110);
    confirm_raw = 1'b0; higher_raw = 1'b0;
    repeat (10) step();

    // lower pressed while higher held
    clear_counts();
    higher_raw = 1'b1;
    repeat (12) step();
    check("t32_hi_count", n_hi, 1);
    clear_counts();
    lower_raw = 1'b1;
    repeat (12) step();
    check("t32_lo_while_held", n_lo, (LOCKOUT != 0) ? 0 : 1);
    check("t32_level_both", btn_level, 3'b011);
    higher_raw = 1'b0; lower_raw = 1'b0;
    repeat (10) step();
    clear_counts();
    lower_raw = 1'b1;
    repeat (12) step();
    check("t32_lo_after_release", n_lo, 1);
    check("t32_lo_latency", first_lo - mark, 7);
    lower_raw = 1'b0;
    repeat (10) step();

    // reset clears a held debounced level immediately, mid-cycle
    confirm_raw = 1'b1;
    repeat (12) step();
    check("async_pre_level", btn_level, 3'b100);
    #2 reset = 1'b0;
    #1;
    check("async_level_cleared", btn_level, 3'b000);
    confirm_raw = 1'b0;
    repeat (2) step();
    reset = 1'b1;
    clear_counts();
    repeat (10) step();
    check("async_after_pulses", n_hi + n_lo + n_cf, 0);

    // reset mid-debounce, higher held through release
    clear_counts();
    higher_raw = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step();
    check("t33_in_reset_out", {confirm_btn, higher_btn, lower_btn, btn_level}, 6'b0);
    step();
    check("t33_in_reset_out2", {confirm_btn, higher_btn, lower_btn, btn_level}, 6'b0);
    check("t33_no_pulse_pre", n_hi, 0);
    reset = 1'b1;
    clear_counts();
    repeat (20) step();
    check("t33_hi_count", n_hi, 1);
    check("t33_hi_latency", first_hi - mark, 7);
    higher_raw = 1'b0;
    repeat (10) step();

    check("exclusive_pulses", n_ovl, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
